rr_arbiter: RTL

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/arb_pkg.sv | 23 ++
 rtl/arb_prio_pick.sv | 44 ++++
 rtl/rr_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state type and helpers for the request arbiter
package arb_pkg;

    // Arbitration mode encodings for the MODE parameter of rr_arbiter.
    localparam int ARB_MODE_FIXED_LSB = 0;
    localparam int ARB_MODE_FIXED_MSB = 1;
    localparam int ARB_MODE_RR        = 2;

    // Width and saturation value of the consecutive-grant counter.
    localparam int                   GNT_CNT_W   = 8;
    localparam logic [GNT_CNT_W-1:0] GNT_CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Increment that sticks at GNT_CNT_MAX instead of wrapping.
    function automatic logic [GNT_CNT_W-1:0] cnt_sat_inc(input logic [GNT_CNT_W-1:0] c);
        return (c == GNT_CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// rtl/arb_prio_pick.sv - combinational priority picker: rotate by pointer, take first set bit
//
// Ports:
//   req       - candidate request vector
//   ptr       - index that gets top priority when searching upward
//   msb_first - search downward from W-1 instead (pointer ignored)
//   found     - at least one candidate was set
//   onehot    - one-hot winner, zero when nothing found
//   idx       - winner index, zero when nothing found
module arb_prio_pick #(
    parameter int W     = 8,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             msb_first,
    output logic             found,
    output logic [W-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int c;
        c      = 0;
        found  = 1'b0;
        idx    = '0;
        // Walk the search order once; the first set candidate wins. The
        // upward walk starts at ptr and wraps, which is the rotated vector.
        for (int k = 0; k < W; k++) begin
            if (msb_first) begin
                c = W - 1 - k;
            end else begin
                c = int'(ptr) + k;
                if (c >= W) c = c - W;
            end
            if (!found && req[IDX_W'(c)]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
        onehot = found ? (W'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - registered N-way arbiter (fixed LSB/MSB or round-robin) with hold counter
//
// Optional feature macro: RR_ARBITER_HOLD_LIMIT_EN (forced rotation after MAX_HOLD cycles).
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - asynchronous active-high reset
//   req       - per-requester request level
//   gnt       - registered grant, zero or one-hot
//   gnt_valid - high iff gnt nonzero
//   gnt_idx   - index of the granted bit, 0 when idle
//   gnt_cnt   - consecutive cycles the current owner has held gnt, saturating
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int W_REQ    = 8,
    parameter int MODE     = ARB_MODE_RR,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W_REQ-1:0]         req,
    output logic [W_REQ-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(W_REQ)-1:0] gnt_idx,
    output logic [GNT_CNT_W-1:0]     gnt_cnt
);

    localparam int IDX_W = $clog2(W_REQ);

`ifdef RR_ARBITER_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    arb_state_t         state_q, state_d;
    logic [W_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GNT_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [W_REQ-1:0]   cand;
    logic               owner_req;
    logic               hold_hit;
    logic               pick_found;
    logic [W_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   pick_ptr;

    // The current owner is never a candidate: either it dropped its request
    // or it is being rotated out by the hold limit. In IDLE gnt_q is zero so
    // every requester is eligible.
    assign cand      = req & ~gnt_q;
    assign owner_req = req[idx_q];
    assign hold_hit  = HOLD_EN && (cnt_q >= GNT_CNT_W'(MAX_HOLD)) && (|cand);
    assign pick_ptr  = (MODE == ARB_MODE_RR) ? ptr_q : '0;

    arb_prio_pick #(
        .W     (W_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (cand),
        .ptr       (pick_ptr),
        .msb_first (MODE == ARB_MODE_FIXED_MSB),
        .found     (pick_found),
        .onehot    (pick_onehot),
        .idx       (pick_idx)
    );

    always_comb begin
        logic take_new;
        logic go_idle;
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        take_new = 1'b0;
        go_idle  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take_new = pick_found;
            end
            ST_OWNED: begin
                if (owner_req && !hold_hit) begin
                    cnt_d = cnt_sat_inc(cnt_q);
                end else if (pick_found) begin
                    take_new = 1'b1;
                end else begin
                    go_idle = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (take_new) begin
            state_d = ST_OWNED;
            gnt_d   = pick_onehot;
            idx_d   = pick_idx;
            cnt_d   = GNT_CNT_W'(1);
            // Next search starts just past the new owner, wrapping at W_REQ.
            ptr_d   = (pick_idx == IDX_W'(W_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if (go_idle) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_cnt   = cnt_q;

endmodule
